// File: rtl/ula_driver.sv
// Request/response front end for a registered ULA: decodes the ALU op, drives the ULA
// operands, waits RESULT_LAT edges for the result and holds it until the consumer takes it.
module ula_driver #(
  parameter int unsigned RESULT_LAT = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_aluop,
  input  logic [5:0]  req_funct,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  output logic [3:0]  ula_ctrl,
  output logic [31:0] ula_a,
  output logic [31:0] ula_b,
  input  logic [31:0] ula_result,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_result,
  output logic        rsp_zero,
  output logic        rsp_err
);

  localparam logic [3:0] LatCnt = 4'(RESULT_LAT);

  typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

  state_e      r_state, w_state_next;
  logic        r_live;
  logic        r_bad;
  logic [3:0]  r_cnt;
  logic [3:0]  r_ctrl;
  logic [31:0] r_a, r_b, r_result;
  logic        r_zero, r_err;
  logic        w_dec_ok;
  logic [3:0]  w_dec_ctrl;
  logic        w_accept, w_capture, w_fail;

  always_comb begin
    w_dec_ok   = 1'b1;
    w_dec_ctrl = 4'b0010;
    case (req_aluop)
      2'b00: w_dec_ctrl = 4'b0010;
      2'b01: w_dec_ctrl = 4'b0110;
      2'b10: begin
        case (req_funct)
          6'b100000: w_dec_ctrl = 4'b0010;
          6'b100010: w_dec_ctrl = 4'b0110;
          6'b100100: w_dec_ctrl = 4'b0000;
          6'b100101: w_dec_ctrl = 4'b0001;
          6'b101010: w_dec_ctrl = 4'b0111;
          default:   w_dec_ok   = 1'b0;
        endcase
      end
      default: w_dec_ok = 1'b0;
    endcase
  end

  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_capture    = 1'b0;
    w_fail       = 1'b0;
    case (r_state)
      StIdle: begin
        if (req_valid && r_live) begin
          w_accept     = 1'b1;
          w_state_next = StExec;
        end
      end
      StExec: begin
        // An undecodable op spends exactly one cycle here before reporting the error.
        if (r_bad) begin
          w_fail       = 1'b1;
          w_state_next = StResp;
        end else if (r_cnt == LatCnt) begin
          w_capture    = 1'b1;
          w_state_next = StResp;
        end
      end
      StResp: begin
        if (rsp_ready) w_state_next = StIdle;
      end
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= StIdle;
      r_live   <= 1'b0;
      r_bad    <= 1'b0;
      r_cnt    <= '0;
      r_ctrl   <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_result <= '0;
      r_zero   <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_live  <= 1'b1;
      if (r_state == StExec) r_cnt <= r_cnt + 4'd1;
      if (w_accept) begin
        r_bad <= ~w_dec_ok;
        r_cnt <= '0;
        if (w_dec_ok) begin
          r_ctrl <= w_dec_ctrl;
          r_a    <= req_a;
          r_b    <= req_b;
        end
      end
      if (w_capture) begin
        r_result <= ula_result;
        r_zero   <= (ula_result == 32'd0);
        r_err    <= 1'b0;
      end
      if (w_fail) begin
        r_result <= '0;
        r_zero   <= 1'b0;
        r_err    <= 1'b1;
      end
    end
  end

  assign req_ready  = r_live && (r_state == StIdle);
  assign rsp_valid  = (r_state == StResp);
  assign ula_ctrl   = r_ctrl;
  assign ula_a      = r_a;
  assign ula_b      = r_b;
  assign rsp_result = r_result;
  assign rsp_zero   = r_zero;
  assign rsp_err    = r_err;

endmodule

// File: tb/tb_ula_driver.sv
// Scoreboard bench: two drivers (RESULT_LAT 1 and 3) share stimulus; each has its own
// registered ULA model, expected-response queue and monitor.
module tb_ula_driver;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic [1:0]  req_aluop = '0;
  logic [5:0]  req_funct = '0;
  logic [31:0] req_a = '0, req_b = '0;
  logic        rsp_ready = 1'b0;

  logic        rdy1, vld1, z1, e1, rdy3, vld3, z3, e3;
  logic [3:0]  ctrl1, ctrl3;
  logic [31:0] ua1, ub1, ur1, rr1, ua3, ub3, ur3, rr3;

  always #5 clk = ~clk;

  ula_driver #(.RESULT_LAT(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(rdy1),
    .req_aluop(req_aluop), .req_funct(req_funct), .req_a(req_a), .req_b(req_b),
    .ula_ctrl(ctrl1), .ula_a(ua1), .ula_b(ub1), .ula_result(ur1),
    .rsp_valid(vld1), .rsp_ready(rsp_ready), .rsp_result(rr1), .rsp_zero(z1), .rsp_err(e1)
  );

  ula_driver #(.RESULT_LAT(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(rdy3),
    .req_aluop(req_aluop), .req_funct(req_funct), .req_a(req_a), .req_b(req_b),
    .ula_ctrl(ctrl3), .ula_a(ua3), .ula_b(ub3), .ula_result(ur3),
    .rsp_valid(vld3), .rsp_ready(rsp_ready), .rsp_result(rr3), .rsp_zero(z3), .rsp_err(e3)
  );

  // Downstream ULA: combinational function behind RESULT_LAT register stages.
  function automatic logic [31:0] alu(input logic [3:0] c, input logic [31:0] a,
                                      input logic [31:0] b);
    case (c)
      4'b0010: return a + b;
      4'b0110: return a - b;
      4'b0000: return a & b;
      4'b0001: return a | b;
      4'b0111: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  logic [31:0] p1;
  logic [31:0] p3 [3];
  always @(posedge clk) begin
    p1    <= alu(ctrl1, ua1, ub1);
    p3[0] <= alu(ctrl3, ua3, ub3);
    p3[1] <= p3[0];
    p3[2] <= p3[1];
  end
  assign ur1 = p1;
  assign ur3 = p3[2];

  typedef struct {
    logic [31:0] res;
    logic        zero;
    logic        err;
    int          acc;
  } exp_t;

  exp_t        q1[$], q3[$];
  int          checks = 0, failures = 0;
  int          cyc = 0;
  bit          live = 1'b0;
  bit          rr_force = 1'b1, rr_val = 1'b1;
  bit          first1 = 1'b1, first3 = 1'b1;
  logic [3:0]  m_ctrl = '0;
  logic [31:0] m_a = '0, m_b = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%h exp=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Reference: operation semantics straight from the op class / funct table.
  function automatic void refm(input logic [1:0] op, input logic [5:0] f,
                               input logic [31:0] a, input logic [31:0] b,
                               output bit ok, output logic [3:0] c, output logic [31:0] r);
    ok = 1'b1; c = '0; r = '0;
    if (op == 2'd0 || (op == 2'd2 && f == 6'h20)) begin c = 4'b0010; r = a + b; end
    else if (op == 2'd1 || (op == 2'd2 && f == 6'h22)) begin c = 4'b0110; r = a - b; end
    else if (op == 2'd2 && f == 6'h24) begin c = 4'b0000; r = a & b; end
    else if (op == 2'd2 && f == 6'h25) begin c = 4'b0001; r = a | b; end
    else if (op == 2'd2 && f == 6'h2a) begin
      c = 4'b0111; r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
    end else ok = 1'b0;
  endfunction

  always @(negedge clk) begin
    if (!rst_n) first1 = 1'b1;
    else if (live) begin
      chk("rdy1", {31'd0, rdy1}, {31'd0, q1.size() == 0});
      chk("ctrl1", {28'd0, ctrl1}, {28'd0, m_ctrl});
      chk("ula_a1", ua1, m_a);
      chk("ula_b1", ub1, m_b);
      if (vld1) begin
        if (q1.size() == 0) chk("spurious_vld1", {31'd0, vld1}, 32'd0);
        else begin
          if (first1) begin
            chk("lat1", cyc - q1[0].acc, q1[0].err ? 32'd1 : 32'd2);
            first1 = 1'b0;
          end
          chk("res1", rr1, q1[0].res);
          chk("zero1", {31'd0, z1}, {31'd0, q1[0].zero});
          chk("err1", {31'd0, e1}, {31'd0, q1[0].err});
          if (rsp_ready) begin void'(q1.pop_front()); first1 = 1'b1; end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst_n) first3 = 1'b1;
    else if (live) begin
      chk("rdy3", {31'd0, rdy3}, {31'd0, q3.size() == 0});
      chk("ctrl3", {28'd0, ctrl3}, {28'd0, m_ctrl});
      chk("ula_a3", ua3, m_a);
      chk("ula_b3", ub3, m_b);
      if (vld3) begin
        if (q3.size() == 0) chk("spurious_vld3", {31'd0, vld3}, 32'd0);
        else begin
          if (first3) begin
            chk("lat3", cyc - q3[0].acc, q3[0].err ? 32'd1 : 32'd4);
            first3 = 1'b0;
          end
          chk("res3", rr3, q3[0].res);
          chk("zero3", {31'd0, z3}, {31'd0, q3[0].zero});
          chk("err3", {31'd0, e3}, {31'd0, q3[0].err});
          if (rsp_ready) begin void'(q3.pop_front()); first3 = 1'b1; end
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      rsp_ready = rr_force ? rr_val : ($urandom_range(3) != 0);
    end
  end

  // Waits for both blocks idle, throwing junk requests at them while both are busy.
  // dir selects the hand-written expected code/result instead of the model's.
  task automatic issue(input logic [1:0] op, input logic [5:0] f, input logic [31:0] a,
                       input logic [31:0] b, input bit dir, input logic [3:0] dctrl,
                       input logic [31:0] dres);
    bit          ok;
    logic [3:0]  c;
    logic [31:0] r;
    exp_t        e;
    int          guard = 0;
    @(negedge clk);
    while (!(rdy1 && rdy3)) begin
      if (!rdy1 && !rdy3) begin
        req_valid = 1'($urandom_range(1));
        req_aluop = 2'($urandom);
        req_funct = 6'($urandom);
        req_a     = $urandom;
        req_b     = $urandom;
      end else req_valid = 1'b0;
      @(negedge clk);
      guard++;
      if (guard > 300) begin
        chk("issue_timeout", 32'd0, 32'd1);
        req_valid = 1'b0;
        return;
      end
    end
    req_aluop = op; req_funct = f; req_a = a; req_b = b; req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    refm(op, f, a, b, ok, c, r);
    if (dir) begin c = dctrl; r = dres; end
    if (ok) begin m_ctrl = c; m_a = a; m_b = b; end
    e.res  = ok ? r : 32'd0;
    e.zero = ok && (r == 32'd0);
    e.err  = !ok;
    e.acc  = cyc;
    q1.push_back(e);
    q3.push_back(e);
  endtask

  task automatic wait_idle();
    int guard = 0;
    while (q1.size() != 0 || q3.size() != 0) begin
      @(negedge clk);
      guard++;
      if (guard > 300) begin
        chk("drain_timeout", 32'd0, 32'd1);
        return;
      end
    end
    @(negedge clk);
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_rdy"}, {30'd0, rdy1, rdy3}, 32'd0);
    chk({tag, "_vld"}, {30'd0, vld1, vld3}, 32'd0);
    chk({tag, "_ctrl"}, {24'd0, ctrl1, ctrl3}, 32'd0);
    chk({tag, "_ula_ab"}, ua1 | ub1 | ua3 | ub3, 32'd0);
    chk({tag, "_res"}, rr1 | rr3, 32'd0);
    chk({tag, "_zero_err"}, {28'd0, z1, e1, z3, e3}, 32'd0);
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rdy_before_edge", {30'd0, rdy1, rdy3}, 32'd0);
    @(posedge clk);
    #1;
    chk("rdy_after_edge", {30'd0, rdy1, rdy3}, 32'd3);
    live = 1'b1;
  endtask

  initial begin
    int guard;
    logic [1:0]  op;
    logic [5:0]  fn;
    logic [31:0] a, b;
    logic [5:0]  fset [6];
    fset[0] = 6'h20; fset[1] = 6'h22; fset[2] = 6'h24;
    fset[3] = 6'h25; fset[4] = 6'h2a; fset[5] = 6'h00;

    repeat (3) @(negedge clk);
    chk_reset_outs("reset");
    release_reset();

    issue(2'b10, 6'b100000, 32'd5, 32'd7, 1'b1, 4'b0010, 32'd12);
    issue(2'b01, 6'b000000, 32'd9, 32'd9, 1'b1, 4'b0110, 32'd0);
    issue(2'b10, 6'b101010, 32'd3, 32'd8, 1'b1, 4'b0111, 32'd1);
    issue(2'b11, 6'b000000, 32'd1, 32'd2, 1'b0, 4'b0000, 32'd0);
    issue(2'b10, 6'b100101, 32'h10, 32'h1, 1'b1, 4'b0001, 32'h11);
    wait_idle();

    // Backpressure: hold rsp_ready low while the LAT=1 response waits.
    rr_force = 1'b1; rr_val = 1'b0;
    issue(2'b10, 6'b100100, 32'hFFFF_0000, 32'h0F0F_0F0F, 1'b1, 4'b0000, 32'h0F0F_0000);
    guard = 0;
    while (!vld1 && guard < 20) begin @(negedge clk); guard++; end
    chk("bp_vld_seen", {31'd0, vld1}, 32'd1);
    repeat (5) issue_junk_cycle();
    chk("bp_vld_held", {31'd0, vld1}, 32'd1);
    chk("bp_res_held", rr1, 32'h0F0F_0000);
    rr_val = 1'b1;
    wait_idle();

    rr_force = 1'b0;
    for (int i = 0; i < 150; i++) begin
      op = 2'($urandom);
      fn = fset[$urandom_range(5)];
      if ($urandom_range(9) == 0) fn = 6'($urandom);
      a = ($urandom_range(3) == 0) ? 32'($urandom_range(4)) : $urandom;
      b = ($urandom_range(3) == 0) ? a : $urandom;
      issue(op, fn, a, b, 1'b0, 4'd0, 32'd0);
    end
    wait_idle();

    // Reset one cycle after accept: both blocks are still in EXEC.
    rr_force = 1'b1; rr_val = 1'b1;
    issue(2'b00, 6'b000000, 32'h1234, 32'h1, 1'b0, 4'd0, 32'd0);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    live  = 1'b0;
    #1;
    chk_reset_outs("async_reset");
    q1.delete(); q3.delete();
    m_ctrl = '0; m_a = '0; m_b = '0;
    repeat (3) begin
      @(negedge clk);
      chk("no_vld_in_reset", {30'd0, vld1, vld3}, 32'd0);
    end
    release_reset();
    issue(2'b10, 6'b100010, 32'd20, 32'd5, 1'b1, 4'b0110, 32'd15);
    wait_idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  task automatic issue_junk_cycle();
    req_valid = 1'b1;
    req_aluop = 2'b00;
    req_a     = $urandom;
    req_b     = $urandom;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/ula_driver.md
ULA_DRIVER -- requirements
Module: ula_driver

Interface
REQ-001 SHALL have parameter RESULT_LAT, default 1, meaning the number of clock edges the downstream ULA takes to present a result after sampling its control code and operands; legal range 1..15.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset; one clock, reset is asynchronous and active-low.
REQ-004 SHALL have port req_valid  input  1  operation request valid.
REQ-005 SHALL have port req_ready  output  1  block can accept a request.
REQ-006 SHALL have port req_aluop  input  2  main-control ALU op class.
REQ-007 SHALL have port req_funct  input  6  R-type funct field.
REQ-008 SHALL have port req_a  input  32  operand A.
REQ-009 SHALL have port req_b  input  32  operand B.
REQ-010 SHALL have port ula_ctrl  output  4  control code driven to the ULA.
REQ-011 SHALL have port ula_a  output  32  operand A driven to the ULA.
REQ-012 SHALL have port ula_b  output  32  operand B driven to the ULA.
REQ-013 SHALL have port ula_result  input  32  registered result returned by the ULA.
REQ-014 SHALL have port rsp_valid  output  1  response valid.
REQ-015 SHALL have port rsp_ready  input  1  consumer accepts response.
REQ-016 SHALL have port rsp_result  output  32  captured result.
REQ-017 SHALL have port rsp_zero  output  1  rsp_result equals zero.
REQ-018 SHALL have port rsp_err  output  1  request carried an undecodable operation.

Function
REQ-019 SHALL implement states IDLE, EXEC, RESP; req_ready = 1 only in IDLE; no request bypass.
REQ-020 SHALL decode: aluop 00 -> 0010 (add); 01 -> 0110 (sub); 10 with funct 100000 -> 0010, 100010 -> 0110, 100100 -> 0000 (and), 100101 -> 0001 (or), 101010 -> 0111 (slt); any other aluop/funct combination, including aluop 11, is invalid.
REQ-021 SHALL, on the edge where req_valid & req_ready and the op is valid, register the code into ula_ctrl, req_a into ula_a, req_b into ula_b, clear the 4-bit wait counter, and enter EXEC.
REQ-022 SHALL hold ula_ctrl, ula_a, ula_b stable for the whole of EXEC and RESP; in IDLE they retain their last values.
REQ-023 SHALL, in EXEC, increment the counter on each edge; on the edge where counter == RESULT_LAT, capture ula_result into rsp_result, set rsp_zero = (ula_result == 0), set rsp_err = 0, and enter RESP.
REQ-024 SHALL give latency from accept edge to rsp_valid high of RESULT_LAT+1 cycles (2 cycles at default).
REQ-025 SHALL, on accepting an invalid op, leave ula_ctrl/ula_a/ula_b unchanged, go directly to RESP on the next edge with rsp_result = 0, rsp_zero = 0, rsp_err = 1.
REQ-026 SHALL assert rsp_valid only in RESP; rsp_result/rsp_zero/rsp_err stable while rsp_valid & !rsp_ready.
REQ-027 SHALL, on the edge with rsp_valid & rsp_ready, return to IDLE; the next request is accepted no earlier than the following edge.
REQ-028 SHALL ignore req_* inputs while not in IDLE; ignore rsp_ready outside RESP.

Reset
REQ-029 SHALL, while rst_n = 0, force state IDLE, counter 0, ula_ctrl 0000, ula_a 0, ula_b 0, rsp_result 0, rsp_zero 0, rsp_err 0, rsp_valid 0, req_ready 0.
REQ-030 SHALL drive req_ready = 1 from the first clk edge after rst_n deasserts.
REQ-031 SHALL, on reset assertion in EXEC or RESP, abandon the operation immediately with no response produced.

Verification
REQ-032 Add: aluop 10, funct 100000, a 5, b 7, rsp_ready 1 -> ula_ctrl 0010, rsp_valid 2 cycles after accept, result 12, zero 0, err 0.
REQ-033 Sub to zero: aluop 01, a 9, b 9 -> ula_ctrl 0110, result 0, zero 1; then slt aluop 10 funct 101010 a 3 b 8 -> 0111, result 1.
REQ-034 Invalid: aluop 11, funct 000000 -> ula_ctrl unchanged, rsp_valid 1 cycle after accept, result 0, err 1.
REQ-035 Backpressure: and a FFFF0000 b 0F0F0F0F, rsp_ready 0 for 5 cycles -> rsp_valid held, result 0F0F0000 stable, req_ready 0 throughout, second request issued meanwhile not accepted.
REQ-036 RESULT_LAT 3: or a 00000010 b 00000001 -> rsp_valid 4 cycles after accept, result 00000011; ula_a/ula_b/ula_ctrl constant during EXEC.
REQ-037 Reset mid-EXEC: drop rst_n one cycle after accept -> all outputs to reset values asynchronously, no rsp_valid pulse, req_ready 1 one edge after release.
